// File: rtl/vga_sync_gen.sv
// VGA sync generator.
// Counts pixels (h_cnt) and lines (v_cnt) on pix_ce qualified clk edges and
// produces registered sync, blanking, position and line/frame strobes.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   pix_ce       pixel-clock enable, one clk wide
//   hsync        horizontal sync, active level SYNC_POL
//   vsync        vertical sync, active level SYNC_POL
//   video_on     visible-area flag
//   x, y         current horizontal / vertical count
//   line_start   one-clk strobe when x first shows 0 after a horizontal wrap
//   frame_start  one-clk strobe, coincident with line_start, when y also wraps
module vga_sync_gen #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  HMax     = 10'(H_TOT - 1);
  localparam logic [9:0]  VMax     = 10'(V_TOT - 1);
  localparam logic [9:0]  HVis     = 10'(H_VIS);
  localparam logic [9:0]  VVis     = 10'(V_VIS);
  // Sync window bounds get an extra bit so an end value of 1024 does not wrap.
  localparam logic [10:0] HSyncOn  = 11'(H_VIS + H_FP);
  localparam logic [10:0] HSyncOff = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VSyncOn  = 11'(V_VIS + V_FP);
  localparam logic [10:0] VSyncOff = 11'(V_VIS + V_FP + V_SYNC);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  // run_q is clear after reset until the first pix_ce edge; that edge only
  // arms the counters so position (0,0) lasts a full pixel period.
  logic       run_q, run_d;
  logic       lwrap_q, lwrap_d;
  logic       fwrap_q, fwrap_d;

  logic       hsync_d, vsync_d, video_on_d;
  logic       h_in_sync, v_in_sync;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    run_d   = run_q;
    lwrap_d = 1'b0;
    fwrap_d = 1'b0;
    if (pix_ce) begin
      if (!run_q) begin
        run_d = 1'b1;
      end else if (h_cnt_q == HMax) begin
        h_cnt_d = '0;
        lwrap_d = 1'b1;
        if (v_cnt_q == VMax) begin
          v_cnt_d = '0;
          fwrap_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Output decode of the counters as held this cycle; registered below.
  always_comb begin
    h_in_sync  = ({1'b0, h_cnt_q} >= HSyncOn) && ({1'b0, h_cnt_q} < HSyncOff);
    v_in_sync  = ({1'b0, v_cnt_q} >= VSyncOn) && ({1'b0, v_cnt_q} < VSyncOff);
    hsync_d    = h_in_sync ? SYNC_POL : ~SYNC_POL;
    vsync_d    = v_in_sync ? SYNC_POL : ~SYNC_POL;
    video_on_d = run_q && (h_cnt_q < HVis) && (v_cnt_q < VVis);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      run_q       <= 1'b0;
      lwrap_q     <= 1'b0;
      fwrap_q     <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      run_q       <= run_d;
      lwrap_q     <= lwrap_d;
      fwrap_q     <= fwrap_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      video_on    <= video_on_d;
      x           <= h_cnt_q;
      y           <= v_cnt_q;
      // Wrap flags were set on the wrap edge; the strobe lands with x = 0.
      line_start  <= lwrap_q;
      frame_start <= fwrap_q;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: two small-timing builds (both sync
// polarities) and one default-timing build share the same stimulus. A
// behavioural model pushes each instance's expected outputs when inputs are
// driven; they are popped and compared one clk later.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;

  always #5 clk = ~clk;

  logic       hs [3];
  logic       vs [3];
  logic       von [3];
  logic [9:0] xo [3];
  logic [9:0] yo [3];
  logic       ls [3];
  logic       fs [3];

  vga_sync_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .hsync(hs[0]), .vsync(vs[0]),
    .video_on(von[0]), .x(xo[0]), .y(yo[0]), .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_sync_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) u_small_p (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .hsync(hs[1]), .vsync(vs[1]),
    .video_on(von[1]), .x(xo[1]), .y(yo[1]), .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_sync_gen u_dflt (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .hsync(hs[2]), .vsync(vs[2]),
    .video_on(von[2]), .x(xo[2]), .y(yo[2]), .line_start(ls[2]), .frame_start(fs[2])
  );

  // Model parameters per instance.
  int m_hv [3] = '{8, 8, 640};
  int m_hf [3] = '{2, 2, 16};
  int m_hs [3] = '{3, 3, 96};
  int m_hb [3] = '{2, 2, 48};
  int m_vv [3] = '{4, 4, 480};
  int m_vf [3] = '{1, 1, 10};
  int m_vs [3] = '{2, 2, 2};
  int m_vb [3] = '{1, 1, 33};
  bit m_pol [3] = '{1'b0, 1'b1, 1'b0};

  // Model state: linear pixel index within the frame, armed flag, last x.
  int         m_pos [3] = '{0, 0, 0};
  bit         m_started [3] = '{1'b0, 1'b0, 1'b0};
  logic [9:0] m_prev_x [3] = '{10'd0, 10'd0, 10'd0};

  logic [74:0] sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  // Default-instance hsync pulse tracking.
  logic prev_hs_d = 1'b1;
  int   hs_low_cnt = 0;
  int   vid_cnt = 0;

  task automatic check(input string tag, input logic [24:0] act, input logic [24:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected {hsync, vsync, video_on, line_start, frame_start, x, y} after the
  // coming edge, then advance the model across that edge.
  task automatic model(input int i, input logic r, input logic ce, output logic [24:0] o);
    int   htot, vtot, h, v;
    logic pol, hsy, vsy, vid, lst, fst;
    htot = m_hv[i] + m_hf[i] + m_hs[i] + m_hb[i];
    vtot = m_vv[i] + m_vf[i] + m_vs[i] + m_vb[i];
    pol  = m_pol[i];
    if (r) begin
      o = {~pol, ~pol, 3'b000, 20'd0};
    end else begin
      h   = m_pos[i] % htot;
      v   = m_pos[i] / htot;
      vid = m_started[i] && (h < m_hv[i]) && (v < m_vv[i]);
      hsy = (h >= m_hv[i] + m_hf[i] && h < m_hv[i] + m_hf[i] + m_hs[i]) ? pol : ~pol;
      vsy = (v >= m_vv[i] + m_vf[i] && v < m_vv[i] + m_vf[i] + m_vs[i]) ? pol : ~pol;
      lst = (h == 0) && (m_prev_x[i] != 10'd0);
      fst = lst && (v == 0);
      o   = {hsy, vsy, vid, lst, fst, 10'(h), 10'(v)};
    end
    m_prev_x[i] = o[19:10];
    if (r) begin
      m_pos[i]     = 0;
      m_started[i] = 1'b0;
    end else if (ce) begin
      if (m_started[i]) m_pos[i] = (m_pos[i] + 1) % (htot * vtot);
      else              m_started[i] = 1'b1;
    end
  endtask

  function automatic logic [24:0] observed(input int i);
    return {hs[i], vs[i], von[i], ls[i], fs[i], xo[i], yo[i]};
  endfunction

  task automatic tick(input logic r, input logic ce);
    logic [24:0] e0, e1, e2;
    logic [74:0] ent;
    rst    = r;
    pix_ce = ce;
    model(0, r, ce, e0);
    model(1, r, ce, e1);
    model(2, r, ce, e2);
    sb_q.push_back({e0, e1, e2});
    @(posedge clk);
    #1;
    ent = sb_q.pop_front();
    check("small_pol0", observed(0), ent[74:50]);
    check("small_pol1", observed(1), ent[49:25]);
    check("default",    observed(2), ent[24:0]);
    // Independent timing checks on the default build's line timing.
    if (!r) begin
      if (prev_hs_d && !hs[2]) check("hsync_start_x", 25'(xo[2]), 25'd656);
      if (!prev_hs_d && hs[2]) check("hsync_low_len", 25'(hs_low_cnt), 25'd96);
      if (xo[2] == 10'd0 && ls[2] && yo[2] == 10'd1)
        check("video_on_len", 25'(vid_cnt), 25'd640);
    end
    if (!hs[2]) hs_low_cnt++;
    else        hs_low_cnt = 0;
    if (ls[2] || r) vid_cnt = 0;
    if (von[2])     vid_cnt++;
    prev_hs_d = hs[2];
  endtask

  initial begin
    repeat (3) tick(1'b1, 1'b0);
    // Continuous enable across two small frames (120 pixels each).
    repeat (260) tick(1'b0, 1'b1);
    // Enable every 4th clk.
    for (int k = 0; k < 600; k++) tick(1'b0, (k % 4) == 3);
    // Random enable pattern.
    repeat (500) tick(1'b0, 1'($urandom_range(0, 1)));
    // Reset with pix_ce high mid-frame, then release with enable idle.
    repeat (2) tick(1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    repeat (50) tick(1'b0, 1'b1);
    // Freeze for 1000 clk mid-line.
    repeat (1000) tick(1'b0, 1'b0);
    repeat (50) tick(1'b0, 1'b1);
    // Restart and run the default build over two full lines.
    tick(1'b1, 1'b0);
    repeat (1700) tick(1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VIS, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels; H_TOT = sum of the four, 800 by default.
REQ-005 Parameter V_VIS, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vsync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines; V_TOT = sum of the four, 525 by default.
REQ-009 Parameter SYNC_POL, default 0, active level of hsync and vsync (0 = active-low).
REQ-010 clk  input  1  system clock; the single clock of the block.
REQ-011 rst  input  1  reset, synchronous, active-high.
REQ-012 pix_ce  input  1  pixel-clock enable, one clk wide, from the VGA clock divider.
REQ-013 hsync  output  1  horizontal sync, registered.
REQ-014 vsync  output  1  vertical sync, registered.
REQ-015 video_on  output  1  high while the displayed position is visible, registered.
REQ-016 x  output  10  current horizontal count, registered.
REQ-017 y  output  10  current vertical count, registered.
REQ-018 line_start  output  1  one-clk strobe at the start of each line.
REQ-019 frame_start  output  1  one-clk strobe at the start of each frame.

Function
REQ-020 Internal h_cnt (0..H_TOT-1) and v_cnt (0..V_TOT-1) change only on clk edges where pix_ce=1; with pix_ce=0 all outputs hold, and strobes are 0.
REQ-021 On a pix_ce edge: h_cnt increments; at H_TOT-1 it wraps to 0 and v_cnt increments; v_cnt at V_TOT-1 wraps to 0 in the same edge that h_cnt wraps.
REQ-022 Outputs are registered decodes of the counters with one clk latency: the outputs in cycle n describe the counter values held during cycle n-1.
REQ-023 x = h_cnt and y = v_cnt, with no clamping in blanking.
REQ-024 video_on = 1 iff h_cnt < H_VIS and v_cnt < V_VIS.
REQ-025 hsync = SYNC_POL iff H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC; otherwise hsync = !SYNC_POL.
REQ-026 vsync = SYNC_POL iff V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC, over whole lines; otherwise vsync = !SYNC_POL.
REQ-027 line_start = 1 for exactly one clk, in the output cycle where x first shows 0 after a horizontal wrap.
REQ-028 frame_start = 1 for exactly one clk, coincident with line_start, when the wrap also brought v_cnt to 0.
REQ-029 Strobes fire only on wraps; leaving reset does not produce a strobe.
REQ-030 pix_ce held high every clk is legal; the block then advances one pixel per clk.
REQ-031 Counter and compare widths are 10 bits; parameters giving H_TOT or V_TOT > 1024 are unsupported.

Reset
REQ-032 While rst=1 at a clk edge: h_cnt=0, v_cnt=0, x=0, y=0, video_on=0, hsync=vsync=!SYNC_POL, line_start=0, frame_start=0.
REQ-033 rst has priority over pix_ce.
REQ-034 Reset mid-frame aborts the frame; counting restarts at (0,0) on the first pix_ce edge after rst deasserts.
REQ-035 In the first clk after rst deasserts, outputs still show the reset values, per the latency in REQ-022.

Verification
REQ-036 Reset, then pix_ce every 4th clk for 2 frames -> frame_start period 4*800*525 = 1,680,000 clk; line_start period 3200 clk.
REQ-037 Default params, pix_ce=1 continuous -> hsync low for exactly 96 clk starting at x=656; video_on high for 640 clk per visible line.
REQ-038 Same setup -> vsync low for exactly 2 lines (1600 pixels) starting at y=490, x=0; video_on=0 for all of lines 480..524.
REQ-039 rst pulsed at x=300, y=200 -> next clk shows the REQ-032 values; x=0, y=0 one clk after the first pix_ce edge following rst release; no strobe on release.
REQ-040 pix_ce held 0 for 1000 clk mid-line -> x, y, hsync, vsync and video_on frozen; no strobes.
REQ-041 SYNC_POL=1 build -> hsync/vsync active-high with identical timing; reset value 0.
